// File: rtl/div_4bit_pkg.sv
// Shared definitions for the arithmetic labs:
// operand width, iteration count and FSM states.
package div_4bit_pkg;

  localparam int DIV_WIDTH = 4;
  localparam int DIV_ITERS = 4;
  localparam int CNT_W     = $clog2(DIV_ITERS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/div_4bit_sub.sv
// Trial subtractor for the divider:
// x - y with a borrow-out when x < y.
module sub_5bit #(
  parameter int W = 5
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  output logic [W-1:0] d,
  output logic         bout
);

  // widen by one bit so the top bit carries the borrow
  always_comb begin
    {bout, d} = {1'b0, x} - {1'b0, y};
  end

endmodule

// File: rtl/div_4bit.sv
// Sequential restoring divider, one quotient
// bit per clock, MSB first.
module div_4bit
  import div_4bit_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             div_zero
);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] quo_nxt;
  logic [WIDTH:0]   rem;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic [WIDTH:0]   rem_nxt;
  logic             borrow;
  logic [CNT_W-1:0] cnt;
  logic             last;

  sub_5bit #(
    .W (WIDTH + 1)
  ) u_sub (
    .x    (shifted),
    .y    ({1'b0, dvs}),
    .d    (diff),
    .bout (borrow)
  );

  // one restoring step: shift, trial subtract, keep or restore
  always_comb begin
    shifted = (WIDTH + 1)'({rem, dvd[WIDTH-1]});
    rem_nxt = borrow ? shifted : diff;
    quo_nxt = WIDTH'({quo, ~borrow});
    last    = (cnt == CNT_W'(DIV_ITERS - 1));
  end

  // next-state selection
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = (b == '0) ? DONE : CALC;
        end
      end
      CALC: begin
        if (last) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // state, datapath and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      q        <= '0;
      r        <= '0;
      div_zero <= 1'b0;
      dvd      <= '0;
      dvs      <= '0;
      quo      <= '0;
      rem      <= '0;
      cnt      <= '0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt == CALC);
      done  <= (state_nxt == DONE);
      case (state)
        IDLE: begin
          if (start) begin
            if (b != '0) begin
              dvd <= a;
              dvs <= b;
              quo <= '0;
              rem <= '0;
              cnt <= '0;
            end else begin
              q        <= '1;
              r        <= a;
              div_zero <= 1'b1;
            end
          end
        end
        CALC: begin
          dvd <= dvd << 1;
          rem <= rem_nxt;
          quo <= quo_nxt;
          cnt <= cnt + CNT_W'(1);
          if (last) begin
            q        <= quo_nxt;
            r        <= rem_nxt[WIDTH-1:0];
            div_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
